// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//
// Round-robin arbiter for four bus masters that share one address/data bus.
// The registered owner index steers the master-side mux in front of the
// address decoder. Requests and grants are active-low. An optional hold limit
// revokes a grant after MAX_HOLD cycles when another master is waiting.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles under contention (0 = no limit)
//   CNT_W     hold counter width, MAX_HOLD < 2**CNT_W
//
// Ports
//   clk                 clock
//   reset               asynchronous reset, active-high
//   m0_req_..m3_req_    bus requests, active-low
//   m0_grnt_..m3_grnt_  bus grants, active-low, at most one low at a time
//   owner               index of the granted master, valid while busy=1
//   busy                1 while some master holds the grant
//   arb_tmo             one-cycle pulse when a grant is revoked by the limit
//
// State table
//   state   | meaning
//   ST_IDLE | no grant outstanding, waiting for any request
//   ST_OWN  | owner_q holds the bus; hold_cnt_q counts its extra cycles
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       busy,
  output logic       arb_tmo
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Saturation point of the hold counter. With a limit, the counter stops at
  // MAX_HOLD-1 so a master that held the bus uncontended is revoked as soon
  // as somebody else asks. Without a limit it simply stops at all-ones.
  localparam logic [CNT_W-1:0] HOLD_SAT =
    (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);

  state_t           state_q;
  logic [1:0]       last_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [1:0]       owner_q;
  logic             busy_q;
  logic             tmo_q;
  logic [3:0]       grnt_q;

  logic [3:0]       req;
  logic [3:0]       others;
  logic [1:0]       idx;
  logic [1:0]       win;
  logic             win_valid;
  logic [3:0]       grnt_win_d;
  logic [CNT_W-1:0] hold_inc_d;
  logic             limit_hit;

  assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  // Requests from everyone except the current owner.
  assign others = req & ~(4'b0001 << owner_q);

  // Rotating priority: last_q+1 first, last_q itself last. Walking the
  // offsets from 4 down to 1 lets the nearest asserted request win.
  always_comb begin
    win_valid = 1'b0;
    win       = last_q;
    idx       = last_q;
    for (int k = 4; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (req[idx]) begin
        win       = idx;
        win_valid = 1'b1;
      end
    end
  end

  assign grnt_win_d = ~(4'b0001 << win);
  assign hold_inc_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 1'b1;

  // In ST_OWN the owner sits at last_q, i.e. at the lowest priority, so when
  // the limit fires the search above always lands on a different master.
  assign limit_hit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_SAT) &&
                     req[owner_q] && (others != 4'b0000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 2'd3;
      hold_cnt_q <= '0;
      owner_q    <= 2'd0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
      grnt_q     <= 4'hF;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            state_q    <= ST_OWN;
            owner_q    <= win;
            last_q     <= win;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
            grnt_q     <= grnt_win_d;
          end
        end
        ST_OWN: begin
          if (!req[owner_q]) begin
            // Owner released: hand over at the same edge if anyone waits.
            if (win_valid) begin
              owner_q    <= win;
              last_q     <= win;
              hold_cnt_q <= '0;
              grnt_q     <= grnt_win_d;
            end else begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              hold_cnt_q <= '0;
              grnt_q     <= 4'hF;
            end
          end else if (limit_hit) begin
            owner_q    <= win;
            last_q     <= win;
            hold_cnt_q <= '0;
            grnt_q     <= grnt_win_d;
            tmo_q      <= 1'b1;
          end else begin
            hold_cnt_q <= hold_inc_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          grnt_q  <= 4'hF;
        end
      endcase
    end
  end

  assign m0_grnt_ = grnt_q[0];
  assign m1_grnt_ = grnt_q[1];
  assign m2_grnt_ = grnt_q[2];
  assign m3_grnt_ = grnt_q[3];
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign arb_tmo  = tmo_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_rr
//
// Two arbiters share the request lines: one with a 16-cycle hold limit and
// one without. Both are compared every cycle against a behavioural model,
// against a hand-derived vector table, and in directed corner sequences.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_rr;

  logic       clk;
  logic       reset;
  logic [3:0] req_n;

  logic [3:0] g16, g0;
  logic [1:0] own16, own0;
  logic       busy16, busy0, tmo16, tmo0;

  int vectors     = 0;
  int miscompares = 0;

  bus_arbiter_rr #(.MAX_HOLD(16), .CNT_W(8)) dut16 (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m0_grnt_(g16[0]), .m1_grnt_(g16[1]), .m2_grnt_(g16[2]), .m3_grnt_(g16[3]),
    .owner(own16), .busy(busy16), .arb_tmo(tmo16)
  );

  bus_arbiter_rr #(.MAX_HOLD(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m0_grnt_(g0[0]), .m1_grnt_(g0[1]), .m2_grnt_(g0[2]), .m3_grnt_(g0[3]),
    .owner(own0), .busy(busy0), .arb_tmo(tmo0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: who owns the bus, who was granted last, and how many
  // cycles the current grant has been visible.
  typedef struct {
    logic       busy;
    logic [1:0] owner;
    logic [1:0] last;
    logic       tmo;
    int         since;
  } model_t;

  model_t m16, m0;

  typedef struct {
    logic [3:0] req_n;
    logic       busy;
    logic [1:0] owner;
    logic       tmo;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [1:0] pick(input logic [1:0] last, input logic [3:0] r);
    logic [1:0] w;
    bit found;
    w = last;
    found = 0;
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (int'(last) + k) % 4;
      if (!found && r[i]) begin
        w = 2'(i);
        found = 1;
      end
    end
    return w;
  endfunction

  function automatic model_t reset_state();
    model_t s;
    s.busy = 1'b0; s.owner = 2'd0; s.last = 2'd3; s.tmo = 1'b0; s.since = 0;
    return s;
  endfunction

  function automatic model_t mstep(input model_t s, input logic [3:0] rn, input int mh);
    model_t n;
    logic [3:0] r, oth;
    n = s;
    n.tmo = 1'b0;
    r = ~rn;
    oth = s.busy ? (r & ~(4'b0001 << s.owner)) : r;
    if (!s.busy || !r[s.owner]) begin
      if (r != 4'b0000) begin
        n.busy = 1'b1; n.owner = pick(s.last, r); n.last = n.owner; n.since = 0;
      end else begin
        n.busy = 1'b0;
      end
    end else if (mh != 0 && s.since + 1 >= mh && oth != 4'b0000) begin
      n.owner = pick(s.last, oth); n.last = n.owner; n.since = 0; n.tmo = 1'b1;
    end else begin
      n.since = s.since + 1;
    end
    return n;
  endfunction

  task automatic check(input string nm, input model_t m, input logic [3:0] g,
                       input logic [1:0] o, input logic b, input logic t);
    logic [3:0] eg;
    eg = m.busy ? ~(4'b0001 << m.owner) : 4'hF;
    vectors++;
    if (g !== eg || b !== m.busy || t !== m.tmo || (m.busy && o !== m.owner) ||
        $countones(~g) > 1) begin
      miscompares++;
      $display("FAIL %s @%0t: grnt_=%b busy=%b owner=%0d tmo=%b, expected grnt_=%b busy=%b owner=%0d tmo=%b",
               nm, $time, g, b, o, t, eg, m.busy, m.owner, m.tmo);
    end
  endtask

  task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_models(input string nm);
    check({nm, "_h16"}, m16, g16, own16, busy16, tmo16);
    check({nm, "_h0"},  m0,  g0,  own0,  busy0,  tmo0);
  endtask

  // Drive at the falling edge (also releasing any reset), sample 1 after rise.
  task automatic step(input logic [3:0] rn);
    @(negedge clk);
    req_n = rn;
    reset = 1'b0;
    @(posedge clk);
    m16 = mstep(m16, rn, 16);
    m0  = mstep(m0,  rn, 0);
    #1;
    check_models("model");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_n = 4'hF;
    m16 = reset_state();
    m0  = reset_state();
    #1;
    check_models("reset");
  endtask

  initial begin
    int cnt, bad, tmo_seen;
    bit done;
    logic [3:0] rn;
    model_t e;

    reset = 1'b1;
    req_n = 4'hF;
    m16 = reset_state();
    m0  = reset_state();

    // All four request, each keeps the bus three cycles (order 0,1,2,3,0),
    // then master 2 alone for four cycles.
    tbl[0]  = '{4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[3]  = '{4'b0001, 1'b1, 2'd1, 1'b0};
    tbl[4]  = '{4'b0000, 1'b1, 2'd1, 1'b0};
    tbl[5]  = '{4'b0000, 1'b1, 2'd1, 1'b0};
    tbl[6]  = '{4'b0010, 1'b1, 2'd2, 1'b0};
    tbl[7]  = '{4'b0000, 1'b1, 2'd2, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 2'd2, 1'b0};
    tbl[9]  = '{4'b0100, 1'b1, 2'd3, 1'b0};
    tbl[10] = '{4'b0000, 1'b1, 2'd3, 1'b0};
    tbl[11] = '{4'b0000, 1'b1, 2'd3, 1'b0};
    tbl[12] = '{4'b1000, 1'b1, 2'd0, 1'b0};
    tbl[13] = '{4'b1111, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{4'b1011, 1'b1, 2'd2, 1'b0};
    tbl[15] = '{4'b1011, 1'b1, 2'd2, 1'b0};
    tbl[16] = '{4'b1011, 1'b1, 2'd2, 1'b0};
    tbl[17] = '{4'b1011, 1'b1, 2'd2, 1'b0};
    tbl[18] = '{4'b1111, 1'b0, 2'd2, 1'b0};

    do_reset();
    expect_eq("reset_grnt", {28'd0, g16}, 32'hF);
    expect_eq("reset_owner", {30'd0, own16}, 0);
    expect_eq("reset_busy", {31'd0, busy16}, 0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].req_n);
      e = reset_state();
      e.busy = tbl[i].busy; e.owner = tbl[i].owner; e.tmo = tbl[i].tmo;
      check($sformatf("tbl%0d_h16", i), e, g16, own16, busy16, tmo16);
      check($sformatf("tbl%0d_h0", i),  e, g0,  own0,  busy0,  tmo0);
    end

    // Hold limit: m1 owns, m3 waits.
    do_reset();
    step(4'b1101);
    cnt = (g16[1] == 1'b0) ? 1 : 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(4'b0101);
      if (g16[1] == 1'b0) cnt++;
      else begin
        done = 1;
        expect_eq("t3_owner_after_revoke", {30'd0, own16}, 3);
        expect_eq("t3_tmo_pulse", {31'd0, tmo16}, 1);
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL t3_timeout: grant never revoked within 40 cycles, required revoke after 16");
    end
    expect_eq("t3_hold_cycles", cnt, 16);
    step(4'b0101);
    expect_eq("t3_tmo_one_cycle", {31'd0, tmo16}, 0);
    step(4'b1101);
    expect_eq("t3_m1_regains", {30'd0, own16}, 1);
    expect_eq("t3_m1_grnt", {31'd0, g16[1]}, 0);

    // No contention: never revoked.
    do_reset();
    tmo_seen = 0; bad = 0;
    repeat (100) begin
      step(4'b1110);
      if (tmo16 !== 1'b0) tmo_seen++;
      if (g16[0] !== 1'b0) bad++;
    end
    expect_eq("t4_tmo_count", tmo_seen, 0);
    expect_eq("t4_revoked_cycles", bad, 0);

    // Asynchronous reset while m3 holds the bus.
    do_reset();
    step(4'b0111);
    expect_eq("t5_m3_owner", {30'd0, own16}, 3);
    #2;
    reset = 1'b1;
    m16 = reset_state();
    m0  = reset_state();
    #1;
    expect_eq("t5_async_grnt_h16", {28'd0, g16}, 32'hF);
    expect_eq("t5_async_grnt_h0", {28'd0, g0}, 32'hF);
    @(posedge clk);
    #1;
    step(4'b0110);
    expect_eq("t5_m0_wins", {30'd0, own16}, 0);
    expect_eq("t5_busy", {31'd0, busy16}, 1);

    // Unlimited hold: m1 keeps the bus with m2 waiting.
    do_reset();
    step(4'b1101);
    bad = 0;
    repeat (300) begin
      step(4'b1001);
      if (g0[1] !== 1'b0 || tmo0 !== 1'b0) bad++;
    end
    expect_eq("t6_unlimited_hold", bad, 0);

    // Random traffic with occasional resets.
    do_reset();
    rn = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(15) == 0) rn[b] = ~rn[b];
      if ($urandom_range(299) == 0) do_reset();
      else step(rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
